// File: rtl/msg_drop_pkg.sv
// Shared types for the message dropper: mode select encoding and input FSM states.
package msg_drop_pkg;

    typedef enum logic [1:0] {
        MODE_PASS        = 2'd0,
        MODE_DROP_ALL    = 2'd1,
        MODE_DROP_MASKED = 2'd2,
        MODE_DECIMATE    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST message bundle with channel, empty and packet delimiters.
interface avalon_st_if #(
    parameter int DATA_W  = 64,
    parameter int EMPTY_W = 3,
    parameter int CH_W    = 2
);
    logic               valid;
    logic               ready;
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic [CH_W-1:0]    channel;

    modport source (output valid, data, sop, eop, empty, channel, input ready);
    modport sink   (input valid, data, sop, eop, empty, channel, output ready);
endinterface

// File: rtl/avalon_st_skid.sv
// Two-entry registered skid buffer for an Avalon-ST beat; input ready depends only
// on local occupancy, so no combinational path runs from out_ready to in_ready.
module avalon_st_skid #(
    parameter int DATA_W  = 64,
    parameter int EMPTY_W = 3,
    parameter int CH_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [EMPTY_W-1:0] in_empty,
    input  logic [CH_W-1:0]    in_channel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_sop,
    output logic               out_eop,
    output logic [EMPTY_W-1:0] out_empty,
    output logic [CH_W-1:0]    out_channel
);
    localparam int W = DATA_W + EMPTY_W + CH_W + 2;

    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;
    logic         push;
    logic         pop;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign {out_data, out_sop, out_eop, out_empty, out_channel} = mem_q[rd_q];

    // Payload storage carries no reset; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= {in_data, in_sop, in_eop, in_empty, in_channel};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push) wr_q <= ~wr_q;
            if (pop)  rd_q <= ~rd_q;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/msg_drop_ctrl.sv
// Inline Avalon-ST message dropper: per-message forward/drop decision at SOP,
// per-channel decimation and saturating drop counters, registered output stage.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | between messages; next accepted beat should carry SOP
// ST_FWD  | inside a kept message; beats pushed into the skid stage
// ST_DROP | inside a dropped message; beats sunk with ready held high
module msg_drop_ctrl import msg_drop_pkg::*; #(
    parameter int DATA_W  = 64,
    parameter int EMPTY_W = 3,
    parameter int N_CH    = 4,
    parameter int CH_W    = 2,
    parameter int CNT_W   = 32,
    parameter int DEC_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    avalon_st_if.sink             msg_in,
    avalon_st_if.source           msg_out,
    input  logic [1:0]            mode,
    input  logic [N_CH-1:0]       drop_mask,
    input  logic [DEC_W-1:0]      decim_n,
    input  logic                  clear_cnt,
    output logic                  drop_indication,
    output logic [CH_W-1:0]       drop_channel,
    output logic [N_CH*CNT_W-1:0] drop_cnt,
    output logic                  proto_err
);
    localparam logic [CH_W:0] N_CH_L = (CH_W+1)'(N_CH);

    state_e           state_q, state_d;
    logic [DEC_W-1:0] dec_cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_q [N_CH];

    logic             skid_ready;
    logic             sel_mask;
    logic [DEC_W-1:0] sel_dec;
    logic             ch_ok;
    logic             keep_mode;
    logic             drop_dec;
    logic             sink;
    logic             acc;
    logic             push;
    logic             dec_adv;
    logic             dec_wrap;
    logic             drop_ind_d;
    logic             perr_d;

    always_comb begin
        sel_mask = 1'b0;
        sel_dec  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (msg_in.channel == CH_W'(i)) begin
                sel_mask = drop_mask[i];
                sel_dec  = dec_cnt_q[i];
            end
        end
        ch_ok = {1'b0, msg_in.channel} < N_CH_L;
        case (mode_e'(mode))
            MODE_PASS:        keep_mode = 1'b1;
            MODE_DROP_ALL:    keep_mode = 1'b0;
            MODE_DROP_MASKED: keep_mode = !sel_mask;
            MODE_DECIMATE:    keep_mode = (sel_dec == '0);
            default:          keep_mode = 1'b1;
        endcase
        drop_dec = !ch_ok || !keep_mode;
    end

    // A dropped message never waits on downstream backpressure.
    assign sink         = (msg_in.valid && msg_in.sop) ? drop_dec : (state_q == ST_DROP);
    assign msg_in.ready = rst_n && (sink || skid_ready);
    assign acc          = msg_in.valid && msg_in.ready;
    assign push         = acc && (msg_in.sop ? !drop_dec : (state_q == ST_FWD));

    always_comb begin
        state_d    = state_q;
        drop_ind_d = 1'b0;
        perr_d     = 1'b0;
        if (acc) begin
            if (msg_in.sop) begin
                if (state_q != ST_IDLE || !ch_ok) perr_d = 1'b1;
                if (ch_ok && drop_dec)            drop_ind_d = 1'b1;
                if (msg_in.eop)    state_d = ST_IDLE;
                else if (drop_dec) state_d = ST_DROP;
                else               state_d = ST_FWD;
            end else begin
                if (state_q == ST_IDLE) perr_d = 1'b1;
                if (msg_in.eop)         state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            drop_indication <= 1'b0;
            drop_channel    <= '0;
            proto_err       <= 1'b0;
        end else begin
            state_q         <= state_d;
            drop_indication <= drop_ind_d;
            proto_err       <= perr_d;
            if (drop_ind_d) drop_channel <= msg_in.channel;
        end
    end

    // Wrap on >= so a lowered decim_n cannot strand a counter above the new ratio.
    assign dec_adv  = acc && msg_in.sop && ch_ok && (mode_e'(mode) == MODE_DECIMATE);
    assign dec_wrap = (decim_n <= DEC_W'(1)) || (sel_dec >= decim_n - DEC_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]     <= '0;
                dec_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (clear_cnt) begin
                    cnt_q[i] <= '0;
                end else if (drop_ind_d && msg_in.channel == CH_W'(i) && cnt_q[i] != '1) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
                if (dec_adv && msg_in.channel == CH_W'(i)) begin
                    dec_cnt_q[i] <= dec_wrap ? '0 : sel_dec + DEC_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_cnt
        assign drop_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    avalon_st_skid #(
        .DATA_W  (DATA_W),
        .EMPTY_W (EMPTY_W),
        .CH_W    (CH_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (push),
        .in_ready    (skid_ready),
        .in_data     (msg_in.data),
        .in_sop      (msg_in.sop),
        .in_eop      (msg_in.eop),
        .in_empty    (msg_in.empty),
        .in_channel  (msg_in.channel),
        .out_valid   (msg_out.valid),
        .out_ready   (msg_out.ready),
        .out_data    (msg_out.data),
        .out_sop     (msg_out.sop),
        .out_eop     (msg_out.eop),
        .out_empty   (msg_out.empty),
        .out_channel (msg_out.channel)
    );

endmodule

// File: tb/tb_msg_drop_ctrl.sv
// Directed bench for msg_drop_ctrl; channel field is 3 bits so channel 4 can be driven.
module tb_msg_drop_ctrl;
    localparam int DATA_W  = 64;
    localparam int EMPTY_W = 3;
    localparam int N_CH    = 4;
    localparam int CH_W    = 3;
    localparam int CNT_W   = 32;
    localparam int DEC_W   = 8;
    localparam int PW      = DATA_W + 2 + EMPTY_W + CH_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    avalon_st_if #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CH_W(CH_W)) in_if ();
    avalon_st_if #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CH_W(CH_W)) out_if ();

    logic [1:0]            mode;
    logic [N_CH-1:0]       drop_mask;
    logic [DEC_W-1:0]      decim_n;
    logic                  clear_cnt;
    logic                  drop_indication;
    logic [CH_W-1:0]       drop_channel;
    logic [N_CH*CNT_W-1:0] drop_cnt;
    logic                  proto_err;

    msg_drop_ctrl #(
        .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .N_CH(N_CH),
        .CH_W(CH_W), .CNT_W(CNT_W), .DEC_W(DEC_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .msg_in          (in_if),
        .msg_out         (out_if),
        .mode            (mode),
        .drop_mask       (drop_mask),
        .decim_n         (decim_n),
        .clear_cnt       (clear_cnt),
        .drop_indication (drop_indication),
        .drop_channel    (drop_channel),
        .drop_cnt        (drop_cnt),
        .proto_err       (proto_err)
    );

    bit rand_rdy = 1'b0;
    bit rdy_val  = 1'b1;
    bit rnd_bit  = 1'b1;
    assign out_if.ready = rand_rdy ? rnd_bit : rdy_val;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_assert = 0;
    int n_fail   = 0;

    logic [PW-1:0] got_q [$];
    logic [PW-1:0] exp_q [$];
    int            got_cyc [$];
    int            exp_cyc [$];

    int              n_drop_ind = 0;
    int              n_perr     = 0;
    int              stab_err   = 0;
    logic [CH_W-1:0] last_drop_ch = '0;
    bit              prev_stall = 1'b0;
    logic [PW-1:0]   prev_pl;

    function automatic logic [PW-1:0] pk(input logic [DATA_W-1:0] d, input logic s, input logic e,
                                         input logic [EMPTY_W-1:0] em, input logic [CH_W-1:0] c);
        return {d, s, e, em, c};
    endfunction

    function automatic logic [CNT_W-1:0] cnt_of(input int ch);
        return drop_cnt[ch*CNT_W +: CNT_W];
    endfunction

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        logic [PW-1:0] pl;
        pl = pk(out_if.data, out_if.sop, out_if.eop, out_if.empty, out_if.channel);
        if (rst_n) begin
            if (prev_stall && (!out_if.valid || pl !== prev_pl)) stab_err++;
            prev_stall = out_if.valid && !out_if.ready;
            prev_pl    = pl;
            if (out_if.valid && out_if.ready) begin
                got_q.push_back(pl);
                got_cyc.push_back(cyc);
            end
            if (drop_indication) begin
                n_drop_ind++;
                last_drop_ch = drop_channel;
            end
            if (proto_err) n_perr++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input bit s, input bit e, input int ch,
                             input bit exp_fwd, output int waits);
        bit acc;
        int acc_cyc;
        logic [EMPTY_W-1:0] em;
        em = d[EMPTY_W-1:0];
        in_if.valid   = 1'b1;
        in_if.data    = d;
        in_if.sop     = s;
        in_if.eop     = e;
        in_if.empty   = em;
        in_if.channel = CH_W'(ch);
        waits   = 0;
        acc     = 1'b0;
        acc_cyc = 0;
        while (!acc && waits < 200) begin
            @(negedge clk);
            acc     = in_if.ready;
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        if (!acc) check("accept_timeout", 0, 1);
        else if (exp_fwd) begin
            exp_q.push_back(pk(d, s, e, em, CH_W'(ch)));
            exp_cyc.push_back(acc_cyc + 1);
        end
    endtask

    task automatic idle(input int n);
        in_if.valid = 1'b0;
        in_if.sop   = 1'b0;
        in_if.eop   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic compare_out(input string tag, input bit chk_lat);
        int n;
        idle(1);
        rand_rdy = 1'b0;
        rdy_val  = 1'b1;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        idle(3);
        check({tag, " count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s beat %0d", tag, i), got_q[i], exp_q[i]);
            if (chk_lat) check($sformatf("%s latency %0d", tag, i), got_cyc[i], exp_cyc[i]);
        end
        got_q.delete();
        exp_q.delete();
        got_cyc.delete();
        exp_cyc.delete();
    endtask

    initial begin
        int w;
        int w_sum;
        int di0;
        int pe0;
        int len;
        int ch;
        in_if.valid   = 1'b0;
        in_if.data    = '0;
        in_if.sop     = 1'b0;
        in_if.eop     = 1'b0;
        in_if.empty   = '0;
        in_if.channel = '0;
        mode          = 2'd0;
        drop_mask     = '0;
        decim_n       = 8'd0;
        clear_cnt     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst in_ready", in_if.ready, 0);
        check("rst out_valid", out_if.valid, 0);
        check("rst drop_cnt", drop_cnt, 0);
        check("rst drop_ind", drop_indication, 0);
        check("rst proto_err", proto_err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // PASS: three 4-beat messages on channel 1, back to back
        for (int m = 0; m < 3; m++)
            for (int b = 0; b < 4; b++)
                send_beat(64'h1000 + 64'(m * 16 + b), b == 0, b == 3, 1, 1'b1, w);
        compare_out("pass", 1'b1);
        check("pass drop_cnt", drop_cnt, 0);
        check("pass drop_ind", n_drop_ind, 0);

        // DROP_MASKED: ch2 dropped while downstream is stalled
        mode      = 2'd2;
        drop_mask = 4'b0100;
        di0       = n_drop_ind;
        w_sum     = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) rdy_val = 1'b0;
            for (int b = 0; b < 2; b++) begin
                send_beat(64'h2000 + 64'(c * 16 + b), b == 0, b == 1, c, c != 2, w);
                if (c == 2) w_sum += w;
            end
            if (c == 2) rdy_val = 1'b1;
        end
        compare_out("masked", 1'b0);
        check("masked ch2 sink waits", w_sum, 0);
        check("masked drop_ind count", n_drop_ind - di0, 1);
        check("masked drop_channel", last_drop_ch, 2);
        check("masked cnt0", cnt_of(0), 0);
        check("masked cnt1", cnt_of(1), 0);
        check("masked cnt2", cnt_of(2), 1);
        check("masked cnt3", cnt_of(3), 0);

        // DECIMATE 1-of-3 on ch0: messages 1, 4, 7 survive
        mode    = 2'd3;
        decim_n = 8'd3;
        di0     = n_drop_ind;
        for (int i = 0; i < 7; i++)
            send_beat(64'h3000 + 64'(i), 1'b1, 1'b1, 0, (i % 3) == 0, w);
        compare_out("decim", 1'b0);
        check("decim drop_ind count", n_drop_ind - di0, 4);
        check("decim cnt0", cnt_of(0), 4);
        check("decim cnt2", cnt_of(2), 1);
        check("decim cnt3", cnt_of(3), 0);

        // Mode change mid-message applies only from the next SOP
        mode = 2'd0;
        di0  = n_drop_ind;
        send_beat(64'h4000, 1'b1, 1'b0, 3, 1'b1, w);
        mode = 2'd1;
        for (int b = 1; b < 5; b++)
            send_beat(64'h4000 + 64'(b), 1'b0, b == 4, 3, 1'b1, w);
        send_beat(64'h4100, 1'b1, 1'b0, 3, 1'b0, w);
        send_beat(64'h4101, 1'b0, 1'b1, 3, 1'b0, w);
        compare_out("modechg", 1'b0);
        check("modechg drop_ind", n_drop_ind - di0, 1);
        check("modechg cnt3", cnt_of(3), 1);

        // PASS with random downstream ready
        mode     = 2'd0;
        rand_rdy = 1'b1;
        stab_err = 0;
        for (int m = 0; m < 100; m++) begin
            len = $urandom_range(1, 4);
            ch  = $urandom_range(0, 3);
            for (int b = 0; b < len; b++)
                send_beat({$urandom, $urandom}, b == 0, b == len - 1, ch, 1'b1, w);
        end
        compare_out("random", 1'b0);
        check("random stall stability", stab_err, 0);

        // Framing errors
        pe0 = n_perr;
        di0 = n_drop_ind;
        send_beat(64'h5000, 1'b1, 1'b0, 0, 1'b1, w);
        send_beat(64'h5001, 1'b1, 1'b1, 0, 1'b1, w);
        idle(2);
        check("sop in fwd perr", n_perr - pe0, 1);
        send_beat(64'h5002, 1'b0, 1'b1, 1, 1'b0, w);
        idle(2);
        check("non-sop idle perr", n_perr - pe0, 2);
        send_beat(64'h5003, 1'b1, 1'b1, 4, 1'b0, w);
        idle(2);
        check("bad channel perr", n_perr - pe0, 3);
        check("errors drop_ind", n_drop_ind - di0, 0);
        check("errors cnt0", cnt_of(0), 4);
        check("errors cnt1", cnt_of(1), 0);
        compare_out("errors", 1'b0);

        // Clear coincident with a drop leaves counters at zero
        mode      = 2'd1;
        di0       = n_drop_ind;
        clear_cnt = 1'b1;
        send_beat(64'h6000, 1'b1, 1'b1, 1, 1'b0, w);
        clear_cnt = 1'b0;
        idle(2);
        check("clear drop_ind", n_drop_ind - di0, 1);
        check("clear drop_cnt", drop_cnt, 0);
        compare_out("clear", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/msg_drop_ctrl.md
Name: msg_drop_ctrl

Overview:
Parametrised, multi-channel successor to the single-bit message dropper. It sits inline on an Avalon-ST message path and forwards or drops whole messages. The forward/drop decision is made per message at SOP, from a mode select, a per-channel drop mask and per-channel 1-of-N decimation. It keeps per-channel saturating drop counters and feeds the output through a registered skid stage, so timing is closed at full throughput.

Parameters:
DATA_W, 64, data bus width of msg_in/msg_out
EMPTY_W, 3, empty field width (log2 of DATA_W/8)
N_CH, 4, number of channels (channel field values 0..N_CH-1)
CH_W, 2, channel field width, at least clog2(N_CH)
CNT_W, 32, width of each per-channel drop counter
DEC_W, 8, width of the decimation ratio

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
msg_in  avalon_st_if sink  -  uses valid, ready, data, sop, eop, empty, channel
msg_out  avalon_st_if source  -  same fields, registered
mode  in  2  0=PASS, 1=DROP_ALL, 2=DROP_MASKED, 3=DECIMATE
drop_mask  in  N_CH  per-channel drop enable; used in DROP_MASKED only
decim_n  in  DEC_W  forward 1 of every decim_n messages per channel; 0 or 1 forwards all
clear_cnt  in  1  synchronous clear of all drop counters
drop_indication  out  1  1-cycle pulse on the accepted SOP beat of a dropped message
drop_channel  out  CH_W  channel of that message; valid while drop_indication=1
drop_cnt  out  N_CH*CNT_W  per-channel dropped-message counters, channel 0 in the LSBs
proto_err  out  1  1-cycle pulse on a framing violation or an out-of-range channel

Behaviour:
- Clock and reset: one clock domain, clk; asynchronous active-low reset rst_n.
- Reset values: msg_out.valid=0, msg_in.ready=0 while rst_n=0, FSM=IDLE, decimation counters=0, drop_cnt=0, drop_indication=0, proto_err=0. Reset asserted mid-message discards any partial message in flight. After reset the first beat must carry SOP; otherwise it is a proto_err.
- Input FSM, advanced only on an accepted beat (valid&ready):
  - IDLE --sop, keep--> FWD; IDLE --sop, drop--> DROP.
  - sop&eop on the same beat: decision is applied, FSM stays IDLE.
  - FWD/DROP --eop--> IDLE.
- Decision, evaluated once on the SOP beat and held until EOP:
  - PASS: keep.
  - DROP_ALL: drop.
  - DROP_MASKED: drop if drop_mask[channel]=1.
  - DECIMATE: keep if dec_cnt[channel]==0. Then dec_cnt[channel] <= 0 if dec_cnt==decim_n-1 or decim_n<=1, else dec_cnt+1. Only that channel's counter advances.
- Changes to mode, drop_mask or decim_n mid-message do not affect the current message; they apply from the next SOP.
- Ready: in DROP state, and on the SOP beat of a message being dropped, msg_in.ready=1 regardless of msg_out backpressure (the block sinks the beats). Otherwise msg_in.ready = skid stage not full.
- Latency: forwarded beats appear on msg_out 1 cycle after acceptance. Throughput is 1 beat/cycle with msg_out.ready held high. All fields are passed unmodified.
- Skid stage (2 entries): msg_out.valid stays high with stable fields until msg_out.ready. No bubble is inserted when ready toggles.
- Counters:
  - drop_cnt[ch] increments on each dropped SOP and saturates at all-ones.
  - clear_cnt has priority: a clear and an increment in the same cycle leave the counter at 0.
  - decim_n changes do not reset dec_cnt.
- Framing errors, each flagged with a proto_err pulse:
  - SOP seen in FWD/DROP: the beat starts a new message with a fresh decision. A previously forwarded message is left unterminated downstream.
  - Non-SOP beat in IDLE: the beat is dropped and not counted.
  - channel>=N_CH on SOP: the message is dropped and not counted; drop_indication is not asserted.

Decomposition:
- Package msg_drop_pkg holds: mode enum (MODE_PASS, MODE_DROP_ALL, MODE_DROP_MASKED, MODE_DECIMATE) and FSM state enum (ST_IDLE, ST_FWD, ST_DROP).
- Sub-module avalon_st_skid: 2-entry registered skid buffer, parametrised on DATA_W/EMPTY_W/CH_W, reusable elsewhere.
- Top level contains the FSM, the decision logic and the counters.

Test Plan:
- mode=PASS, three 4-beat messages on channel 1, msg_out.ready=1 -> all 12 beats out, 1-cycle latency, no gaps; drop_cnt all 0.
- mode=DROP_MASKED, drop_mask=4'b0100, messages on ch0..ch3, with ready low on the ch2 beats -> ch2 message sunk with ready=1, drop_indication pulses once with drop_channel=2, drop_cnt[2]=1, others forwarded.
- mode=DECIMATE, decim_n=3, 7 single-beat (sop&eop) messages on ch0 -> messages 1, 4 and 7 forwarded; drop_cnt[0]=4; ch3 counter unaffected.
- mode switched PASS->DROP_ALL on beat 2 of a 5-beat message -> the whole message is forwarded; the next message is dropped.
- msg_out.ready random at 50%, 100 random-length messages in PASS -> output beat sequence identical to input; valid/fields stable while ready=0.
- Error cases -> SOP in FWD, non-SOP beat in IDLE, and channel=4 with N_CH=4 each produce one proto_err pulse; clear_cnt asserted alongside a drop leaves the counter at 0.
